// File: rtl/lbp_pkg.sv
// Shared geometry, state encoding, error-bit indices and address helpers
// for the LBP image host and its memories.
package lbp_pkg;

    localparam int unsigned IMG_DIM = 128;
    localparam int unsigned ADDR_W  = 14;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned PIX_N   = 1 << ADDR_W;
    localparam int unsigned ROW_W   = ADDR_W / 2;
    localparam int unsigned CNT_W   = ADDR_W + 1;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SERVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int unsigned ERR_REQ_EARLY = 0;
    localparam int unsigned ERR_WR_EARLY  = 1;
    localparam int unsigned ERR_DUP_WR    = 2;
    localparam int unsigned ERR_FIN_CNT   = 3;

    function automatic logic [ADDR_W-1:0] pack_addr(input logic [ROW_W-1:0] row,
                                                    input logic [ROW_W-1:0] col);
        return {row, col};
    endfunction

    function automatic logic [ROW_W-1:0] addr_row(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:ROW_W];
    endfunction

    function automatic logic [ROW_W-1:0] addr_col(input logic [ADDR_W-1:0] addr);
        return addr[ROW_W-1:0];
    endfunction

endpackage

// File: rtl/lbp_dpram.sv
// Single-write-port, single-asynchronous-read-port memory; contents are not reset.
module lbp_dpram
    import lbp_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [PIX_N];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lbp_image_host.sv
// Memory-side responder for the LBP engine: loads the gray image from a host
// stream, serves zero-latency reads, and captures/checks LBP result writes.
module lbp_image_host
    import lbp_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              gray_ready,
    input  logic              gray_req,
    input  logic [ADDR_W-1:0] gray_addr,
    output logic [DATA_W-1:0] gray_data,
    input  logic              lbp_valid,
    input  logic [ADDR_W-1:0] lbp_addr,
    input  logic [DATA_W-1:0] lbp_data,
    input  logic              finish,
    output logic              done,
    output logic [CNT_W-1:0]  wr_count,
    output logic [3:0]        err_flags,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] gray_rd;
    logic [DATA_W-1:0] gray_hold;
    logic [PIX_N-1:0]  written;
    logic              gray_we;
    logic              lbp_we;
    logic [CNT_W-1:0]  wr_count_nxt;

    assign gray_we = (state == ST_LOAD) && load_valid;
    assign lbp_we  = (state != ST_DONE) && lbp_valid;

    // Saturating count including the write presented this cycle.
    assign wr_count_nxt = (lbp_we && (wr_count != CNT_W'(PIX_N))) ? wr_count + CNT_W'(1)
                                                                  : wr_count;

    // Read data must settle within the request cycle; otherwise hold the last served pixel.
    assign gray_data = ((state == ST_SERVE) && gray_req) ? gray_rd : gray_hold;

    lbp_dpram u_gray_mem (
        .clk   (clk),
        .we    (gray_we),
        .waddr (ptr),
        .wdata (load_data),
        .raddr (gray_addr),
        .rdata (gray_rd)
    );

    lbp_dpram u_lbp_mem (
        .clk   (clk),
        .we    (lbp_we),
        .waddr (lbp_addr),
        .wdata (lbp_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_LOAD;
            load_ready <= 1'b1;
            gray_ready <= 1'b0;
            gray_hold  <= '0;
            done       <= 1'b0;
            wr_count   <= '0;
            err_flags  <= '0;
            ptr        <= '0;
            written    <= '0;
        end else begin
            if (lbp_we) begin
                wr_count          <= wr_count_nxt;
                written[lbp_addr] <= 1'b1;
                if (written[lbp_addr]) begin
                    err_flags[ERR_DUP_WR] <= 1'b1;
                end
                if (state == ST_LOAD) begin
                    err_flags[ERR_WR_EARLY] <= 1'b1;
                end
            end

            case (state)
                ST_LOAD: begin
                    if (gray_req) begin
                        err_flags[ERR_REQ_EARLY] <= 1'b1;
                    end
                    if (load_valid) begin
                        ptr <= ptr + ADDR_W'(1);
                        if (ptr == ADDR_W'(PIX_N - 1)) begin
                            state      <= ST_SERVE;
                            load_ready <= 1'b0;
                            gray_ready <= 1'b1;
                        end
                    end
                end
                ST_SERVE: begin
                    if (gray_req) begin
                        gray_hold <= gray_rd;
                    end
                    if (finish) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        if (wr_count_nxt != CNT_W'(PIX_N)) begin
                            err_flags[ERR_FIN_CNT] <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                end
                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lbp_image_host.sv
// Directed + randomized bench for lbp_image_host; the bench itself plays the
// host loader and the LBP engine, using an array-based image/LBP model.
module tb_lbp_image_host;
    import lbp_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;
    logic              gray_ready;
    logic              gray_req;
    logic [ADDR_W-1:0] gray_addr;
    logic [DATA_W-1:0] gray_data;
    logic              lbp_valid;
    logic [ADDR_W-1:0] lbp_addr;
    logic [DATA_W-1:0] lbp_data;
    logic              finish;
    logic              done;
    logic [CNT_W-1:0]  wr_count;
    logic [3:0]        err_flags;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    int total = 0;
    int bad   = 0;

    logic [7:0] gimg [PIX_N];
    logic [7:0] lres [PIX_N];
    logic [7:0] last_served;

    lbp_image_host dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .gray_ready (gray_ready),
        .gray_req   (gray_req),
        .gray_addr  (gray_addr),
        .gray_data  (gray_data),
        .lbp_valid  (lbp_valid),
        .lbp_addr   (lbp_addr),
        .lbp_data   (lbp_data),
        .finish     (finish),
        .done       (done),
        .wr_count   (wr_count),
        .err_flags  (err_flags),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled before the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        step();
        reset = 1'b0;
    endtask

    task automatic load_image();
        for (int i = 0; i < int'(PIX_N); i++) begin
            if ($urandom_range(0, 15) == 0) begin
                load_valid = 1'b0;
                step();
            end
            load_valid = 1'b1;
            load_data  = gimg[i];
            if (i == int'(PIX_N) - 1) begin
                chk("gray_ready_low_on_last_beat", 32'(gray_ready), 32'd0);
            end
            step();
        end
        load_valid = 1'b0;
        chk("gray_ready_after_load", 32'(gray_ready), 32'd1);
        chk("load_ready_after_load", 32'(load_ready), 32'd0);
    endtask

    task automatic random_reads(input int n);
        logic [ADDR_W-1:0] a;
        for (int k = 0; k < n; k++) begin
            a         = ADDR_W'($urandom_range(0, int'(PIX_N) - 1));
            gray_req  = 1'b1;
            gray_addr = a;
            #1;
            chk("gray_rand_read", 32'(gray_data), 32'(gimg[a]));
            last_served = gimg[a];
            step();
        end
        gray_req = 1'b0;
    endtask

    // LBP: bit set where neighbour >= centre, neighbours in raster order; borders are 0.
    function automatic logic [7:0] lbp_of(input int r, input int c);
        logic [7:0] v;
        int         k;
        v = '0;
        k = 0;
        if (r == 0 || c == 0 || r == int'(IMG_DIM) - 1 || c == int'(IMG_DIM) - 1) begin
            return 8'h00;
        end
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if (!(dr == 0 && dc == 0)) begin
                    v[k] = (gimg[(r + dr) * int'(IMG_DIM) + c + dc] >= gimg[r * int'(IMG_DIM) + c]);
                    k++;
                end
            end
        end
        return v;
    endfunction

    initial begin
        logic [ADDR_W-1:0] a;

        reset       = 1'b1;
        load_valid  = 1'b0;
        load_data   = '0;
        gray_req    = 1'b0;
        gray_addr   = '0;
        lbp_valid   = 1'b0;
        lbp_addr    = '0;
        lbp_data    = '0;
        finish      = 1'b0;
        rd_addr     = '0;
        last_served = '0;
        step();
        step();
        reset = 1'b0;
        #1;

        chk("rst_load_ready", 32'(load_ready), 32'd1);
        chk("rst_gray_ready", 32'(gray_ready), 32'd0);
        chk("rst_gray_data",  32'(gray_data),  32'd0);
        chk("rst_done",       32'(done),       32'd0);
        chk("rst_wr_count",   32'(wr_count),   32'd0);
        chk("rst_err",        32'(err_flags),  32'd0);

        // Read request before the image is loaded.
        gray_req  = 1'b1;
        gray_addr = 14'h0005;
        #1;
        chk("early_req_data", 32'(gray_data), 32'd0);
        step();
        gray_req = 1'b0;
        chk("early_req_err", 32'(err_flags), 32'h1);
        chk("early_req_data_after", 32'(gray_data), 32'd0);

        reset = 1'b1;
        #1;
        chk("async_rst_err_load", 32'(err_flags), 32'd0);
        step();
        reset = 1'b0;

        // Load pattern image: pixel value = low byte of address.
        for (int i = 0; i < int'(PIX_N); i++) begin
            gimg[i] = 8'(i);
        end
        load_image();

        gray_req  = 1'b1;
        gray_addr = 14'h0105;
        #1;
        chk("serve_0105", 32'(gray_data), 32'h05);
        step();
        gray_addr = 14'h3FFF;
        #1;
        chk("serve_3fff", 32'(gray_data), 32'hFF);
        step();
        gray_req  = 1'b0;
        gray_addr = 14'h0105;
        #1;
        chk("hold_no_req", 32'(gray_data), 32'hFF);
        step();
        chk("hold_no_req_2", 32'(gray_data), 32'hFF);
        random_reads(20);

        // Result write and duplicate write.
        lbp_valid = 1'b1;
        lbp_addr  = 14'h0081;
        lbp_data  = 8'hA5;
        step();
        lbp_valid = 1'b0;
        rd_addr   = 14'h0081;
        #1;
        chk("wr1_rd",    32'(rd_data),   32'hA5);
        chk("wr1_count", 32'(wr_count),  32'd1);
        chk("wr1_err",   32'(err_flags), 32'd0);
        lbp_valid = 1'b1;
        lbp_data  = 8'h3C;
        step();
        lbp_valid = 1'b0;
        chk("dup_err",   32'(err_flags), 32'h4);
        chk("dup_rd",    32'(rd_data),   32'h3C);
        chk("dup_count", 32'(wr_count),  32'd2);

        // Asynchronous reset in the middle of SERVE.
        reset = 1'b1;
        #1;
        chk("midrst_load_ready", 32'(load_ready), 32'd1);
        chk("midrst_gray_ready", 32'(gray_ready), 32'd0);
        chk("midrst_err",        32'(err_flags),  32'd0);
        chk("midrst_count",      32'(wr_count),   32'd0);
        chk("midrst_mem_kept",   32'(rd_data),    32'h3C);
        step();
        reset = 1'b0;

        // Result write while still loading.
        lbp_valid = 1'b1;
        lbp_addr  = 14'h0010;
        lbp_data  = 8'h77;
        step();
        lbp_valid = 1'b0;
        rd_addr   = 14'h0010;
        #1;
        chk("early_wr_err",   32'(err_flags),  32'h2);
        chk("early_wr_rd",    32'(rd_data),    32'h77);
        chk("early_wr_count", 32'(wr_count),   32'd1);
        chk("early_wr_state", 32'(load_ready), 32'd1);
        pulse_reset();

        // Reload with a random image, then act as the engine.
        for (int i = 0; i < int'(PIX_N); i++) begin
            gimg[i] = 8'($urandom);
        end
        load_image();
        random_reads(30);

        for (int r = 0; r < int'(IMG_DIM); r++) begin
            for (int c = 0; c < int'(IMG_DIM); c++) begin
                lres[r * int'(IMG_DIM) + c] = lbp_of(r, c);
            end
        end
        for (int i = 0; i < int'(PIX_N); i++) begin
            lbp_valid = 1'b1;
            lbp_addr  = ADDR_W'(i);
            lbp_data  = lres[i];
            finish    = (i == int'(PIX_N) - 1);
            step();
        end
        lbp_valid = 1'b0;
        finish    = 1'b0;
        chk("fin_done",  32'(done),      32'd1);
        chk("fin_count", 32'(wr_count),  32'(PIX_N));
        chk("fin_err",   32'(err_flags), 32'd0);

        rd_addr = pack_addr(7'd0, 7'd0);
        #1;
        chk("rd_corner_00", 32'(rd_data), 32'(lres[0]));
        rd_addr = pack_addr(7'd127, 7'd127);
        #1;
        chk("rd_corner_ff", 32'(rd_data), 32'd0);
        for (int k = 0; k < 40; k++) begin
            a       = ADDR_W'($urandom_range(0, int'(PIX_N) - 1));
            rd_addr = a;
            #1;
            chk("rd_result", 32'(rd_data), 32'(lres[a]));
        end

        // DONE ignores writes and requests.
        lbp_valid = 1'b1;
        lbp_addr  = 14'h0081;
        lbp_data  = ~lres[14'h0081];
        gray_req  = 1'b1;
        gray_addr = 14'h0000;
        rd_addr   = 14'h0081;
        #1;
        chk("done_gray_hold", 32'(gray_data), 32'(last_served));
        step();
        lbp_valid = 1'b0;
        gray_req  = 1'b0;
        chk("done_wr_ignored", 32'(rd_data),   32'(lres[14'h0081]));
        chk("done_err",        32'(err_flags), 32'd0);
        chk("done_count",      32'(wr_count),  32'(PIX_N));
        chk("done_stays",      32'(done),      32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
